and_or_arbiter: RTL and testbench

AND_OR_ARBITER -- requirements
Module: and_or_arbiter

---
 rtl/and_or_arbiter.sv | 106 ++++++++++
 tb/tb_and_or_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/and_or_arbiter.sv
// Two-requester arbiter time-sharing one external AND-OR unit: grant, hold U_IN for EVAL_CYCLES edges, sample U_OUT.
// Define AND_OR_ARB_FIXED_PRIO_EN to make requester 0 always win contention (default: round-robin).
module and_or_arbiter #(
  parameter int EVAL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [3:0] data0,
  input  logic       req1,
  input  logic [3:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] u_in,
  input  logic       u_out,
  output logic       res,
  output logic       res_valid,
  output logic       res_id,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(EVAL_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       owner;
  logic       any_req;
  logic       win;
`ifndef AND_OR_ARB_FIXED_PRIO_EN
  logic       last;
`endif

  always_comb begin
    any_req = req0 | req1;
`ifdef AND_OR_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    // contention goes to whoever was not served last
    win = (req0 & req1) ? ~last : req1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      u_in      <= 4'd0;
      res       <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
`ifndef AND_OR_ARB_FIXED_PRIO_EN
      last      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          res_valid <= 1'b0;
          if (any_req) begin
            gnt0  <= ~win;
            gnt1  <= win;
            u_in  <= win ? data1 : data0;
            cnt   <= CNT_INIT;
            owner <= win;
            busy  <= 1'b1;
            state <= EVAL;
`ifndef AND_OR_ARB_FIXED_PRIO_EN
            last  <= win;
`endif
          end
        end
        EVAL: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // the only edge where the unit's output is observed
            res       <= u_out;
            res_id    <= owner;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_and_or_arbiter.sv
// Directed bench for and_or_arbiter: EVAL_CYCLES=2 main instance plus an EVAL_CYCLES=1 instance.
module tb_and_or_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] data0, data1;
  logic       gnt0, gnt1, res, res_valid, res_id, busy, u_out;
  logic [3:0] u_in;

  logic       b_req0, b_req1;
  logic [3:0] b_data0, b_data1;
  logic       b_gnt0, b_gnt1, b_res, b_res_valid, b_res_id, b_busy, b_u_out;
  logic [3:0] b_u_in;

  int vectors = 0;
  int errs    = 0;

  typedef struct packed { logic id; logic res; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign u_out   = (u_in[0] & u_in[1]) | (u_in[2] & u_in[3]);
  assign b_u_out = (b_u_in[0] & b_u_in[1]) | (b_u_in[2] & b_u_in[3]);

  and_or_arbiter #(.EVAL_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .u_in(u_in), .u_out(u_out), .res(res),
    .res_valid(res_valid), .res_id(res_id), .busy(busy));

  and_or_arbiter #(.EVAL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req0(b_req0), .data0(b_data0), .req1(b_req1), .data1(b_data1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .u_in(b_u_in), .u_out(b_u_out), .res(b_res),
    .res_valid(b_res_valid), .res_id(b_res_id), .busy(b_busy));

  function automatic logic ref_ao(input logic [3:0] d);
    return (d[0] & d[1]) | (d[2] & d[3]);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [3:0] d);
    exp_t e;
    e.id  = id;
    e.res = ref_ao(d);
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, {6'd0, gnt1, gnt0}, 8'd0);
    chk({tag, "_u_in"}, {4'd0, u_in}, 8'd0);
    chk({tag, "_res"}, {5'd0, res, res_id, res_valid}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
  endtask

  // result scoreboard and protocol monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (gnt0 && gnt1) chk("both_gnt", 8'd1, 8'd0);
      if (b_gnt0) chk("b_gnt0_seen", 8'd1, 8'd0);
      if (res_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 8'd1, 8'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_res", {7'd0, res}, {7'd0, e.res});
          chk("sb_res_id", {7'd0, res_id}, {7'd0, e.id});
        end
      end
    end
  end

  initial begin
    logic w;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = 4'd0; data1 = 4'd0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_data0 = 4'd0; b_data1 = 4'd0;
    step(); step();
    chk_zero("reset");
    chk("b_reset_busy", {7'd0, b_busy}, 8'd0);
    rst_n = 1'b1;
    step();

    // single request, data 0011
    req0 = 1'b1; data0 = 4'b0011; push(1'b0, 4'b0011);
    step();
    chk("t32_gnt", {6'd0, gnt1, gnt0}, 8'd1);
    chk("t32_u_in", {4'd0, u_in}, 8'h3);
    chk("t32_busy", {7'd0, busy}, 8'd1);
    req0 = 1'b0;
    step();
    chk("t32_t1", {5'd0, gnt0, res_valid, busy}, 8'b001);
    step();
    chk("t32_t2", {5'd0, res_valid, res, res_id}, 8'b110);
    step();
    chk("t32_t3", {6'd0, res_valid, busy}, 8'd0);
    chk("t32_hold", {3'd0, u_in, res}, {3'd0, 4'b0011, 1'b1});
    step();
    chk("t32_idle", {6'd0, gnt1, gnt0}, 8'd0);

    // contention from fresh reset
    rst_n = 1'b0; step(); rst_n = 1'b1;
    req0 = 1'b1; req1 = 1'b1; data0 = 4'b0101; data1 = 4'b1100;
    for (int k = 0; k < 3; k++) begin
`ifdef AND_OR_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = k[0];
`endif
      push(w, w ? data1 : data0);
      step();
      chk($sformatf("t33_gnt%0d", k), {6'd0, gnt1, gnt0}, w ? 8'd2 : 8'd1);
      if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
      for (int j = 0; j < 3; j++) begin
        step();
        chk($sformatf("t33_quiet%0d_%0d", k, j), {6'd0, gnt1, gnt0}, 8'd0);
      end
    end
    step();
    chk("t33_withdrawn", {6'd0, gnt1, busy}, 8'd0);

    // late req1 waits out the busy window
    req0 = 1'b1; data0 = 4'b1111; push(1'b0, 4'b1111);
    step();
    chk("t34_gnt0", {6'd0, gnt1, gnt0}, 8'd1);
    req0 = 1'b0; req1 = 1'b1; data1 = 4'b1010; push(1'b1, 4'b1010);
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("t34_wait%0d", j), {7'd0, gnt1}, 8'd0);
    end
    step();
    chk("t34_gnt1", {6'd0, gnt1, gnt0}, 8'd2);
    chk("t34_u_in", {4'd0, u_in}, 8'hA);
    req1 = 1'b0;
    step(); step(); step();

    // reset right after a grant discards the transaction
    req0 = 1'b1; data0 = 4'b0011;
    step();
    chk("t35_gnt", {7'd0, gnt0}, 8'd1);
    rst_n = 1'b0; req0 = 1'b0;
    step();
    chk_zero("t35_rst");
    rst_n = 1'b1;
    step(); step();
    chk("t35_no_res", {7'd0, res_valid}, 8'd0);
    req0 = 1'b1; req1 = 1'b1; data0 = 4'b0011; data1 = 4'b1100; push(1'b0, 4'b0011);
    step();
    chk("t35_post_gnt", {6'd0, gnt1, gnt0}, 8'd1);
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // EVAL_CYCLES=1 instance
    b_req1 = 1'b1; b_data1 = 4'b1000;
    step();
    chk("t36_gnt", {6'd0, b_gnt1, b_gnt0}, 8'd2);
    chk("t36_u_in", {4'd0, b_u_in}, 8'h8);
    b_req1 = 1'b0;
    step();
    chk("t36_res", {5'd0, b_res_valid, b_res, b_res_id}, 8'b101);
    chk("t36_gnt_clr", {6'd0, b_gnt1, b_gnt0}, 8'd0);
    step();
    chk("t36_done", {6'd0, b_res_valid, b_busy}, 8'd0);

    step();
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
